// File: rtl/rosetta_loop_sequencer_if.sv
// Controller-facing bundle of the ROSETTA loop sequencer.
// i_* flow into the sequencer (slave), o_* flow back to the controller (master).
interface rosetta_loop_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int IM_AW  = 8
);
    logic [31:0]       i_inst;
    logic              i_im_ren;
    logic              i_pam_x_ren;
    logic              i_x_addr_wen;
    logic              i_r_addr_wen;
    logic              i_x_addr_rst;
    logic              i_r_addr_rst;
    logic              i_inst_done;
    logic [IM_AW-1:0]  o_pc;
    logic              o_nops_cntr_we;
    logic              o_p_last_bound;
    logic              o_p_done;
    logic              o_beta_last_bound;
    logic              o_beta_done;
    logic              o_alp_plus_beta_last_bound;
    logic              o_alp_plus_beta_done;
    logic              o_nops_done;
    logic              o_all_done;
    logic [ADDR_W-1:0] o_x_addr;
    logic [ADDR_W-1:0] o_r_addr;

    modport slave (
        input  i_inst, i_im_ren, i_pam_x_ren,
        input  i_x_addr_wen, i_r_addr_wen,
        input  i_x_addr_rst, i_r_addr_rst, i_inst_done,
        output o_pc, o_nops_cntr_we,
        output o_p_last_bound, o_p_done,
        output o_beta_last_bound, o_beta_done,
        output o_alp_plus_beta_last_bound, o_alp_plus_beta_done,
        output o_nops_done, o_all_done, o_x_addr, o_r_addr
    );

    modport master (
        output i_inst, i_im_ren, i_pam_x_ren,
        output i_x_addr_wen, i_r_addr_wen,
        output i_x_addr_rst, i_r_addr_rst, i_inst_done,
        input  o_pc, o_nops_cntr_we,
        input  o_p_last_bound, o_p_done,
        input  o_beta_last_bound, o_beta_done,
        input  o_alp_plus_beta_last_bound, o_alp_plus_beta_done,
        input  o_nops_done, o_all_done, o_x_addr, o_r_addr
    );
endinterface

// File: rtl/rosetta_loop_sequencer.sv
// ROSETTA loop sequencer: fetch, P/row/NOP loop counters and PAM pointers.
// Optional NOP counter enabled by defining ROSETTA_SEQ_NOPS_EN.
module rosetta_loop_sequencer #(
    parameter int ADDR_W = 10,
    parameter int IM_AW  = 8
) (
    input logic clk,
    input logic rst,
    rosetta_loop_sequencer_if.slave bus
);
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic [IM_AW-1:0]  r_pc;
    logic              r_fetch;
    logic              r_boot;
    logic              r_all_done;
    logic [7:0]        r_p_cnt;
    logic [8:0]        r_row;
    logic [ADDR_W-1:0] r_x_addr;
    logic [ADDR_W-1:0] r_r_addr;

    logic [7:0] w_p;
    logic [6:0] w_alpha;
    logic [7:0] w_beta;
    logic [8:0] w_apb;
    logic       w_we;
    logic       w_p_done;
    logic       w_halt;

    assign w_p      = bus.i_inst[9:2];
    assign w_alpha  = bus.i_inst[23:17];
    assign w_beta   = bus.i_inst[31:24];
    assign w_apb    = {2'b00, w_alpha} + {1'b0, w_beta};
    assign w_halt   = (bus.i_inst == HALT);
    assign w_p_done = (r_p_cnt == w_p);
    // r_boot covers the first post-reset cycle so the word at pc 0 is taken
    assign w_we     = r_fetch | (r_boot & ~rst);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= '0;
            r_fetch <= 1'b0;
            r_boot  <= 1'b1;
        end else begin
            r_pc    <= r_pc + {{(IM_AW-1){1'b0}}, bus.i_im_ren};
            r_fetch <= bus.i_im_ren;
            r_boot  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_cnt <= '0;
            r_row   <= '0;
        end else if (w_we) begin
            r_p_cnt <= '0;
            r_row   <= '0;
        end else if (bus.i_pam_x_ren) begin
            if (w_p_done) begin
                r_p_cnt <= '0;
                if (r_row < w_apb)
                    r_row <= r_row + 9'd1;
            end else begin
                r_p_cnt <= r_p_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_all_done <= 1'b0;
        else if (w_we && w_halt)
            r_all_done <= 1'b1;
    end

`ifdef ROSETTA_SEQ_NOPS_EN
    logic       r_run;
    logic [5:0] r_nop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run     <= 1'b0;
            r_nop_cnt <= '0;
        end else if (w_we) begin
            r_run     <= 1'b0;
            r_nop_cnt <= bus.i_inst[15:10];
        end else begin
            if (r_run && (r_nop_cnt != 6'd0))
                r_nop_cnt <= r_nop_cnt - 6'd1;
            if (bus.i_inst_done)
                r_run <= 1'b1;
        end
    end

    assign bus.o_nops_done = r_run & (r_nop_cnt == 6'd0);
    wire w_unused = ^{bus.i_inst[1:0], bus.i_inst[16]};
`else
    assign bus.o_nops_done = 1'b1;
    wire w_unused = ^{bus.i_inst[1:0], bus.i_inst[16],
                      bus.i_inst[15:10], bus.i_inst_done};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_addr <= '0;
            r_r_addr <= '0;
        end else begin
            if (bus.i_x_addr_rst)
                r_x_addr <= '0;
            else if (bus.i_x_addr_wen)
                r_x_addr <= r_x_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (bus.i_r_addr_rst)
                r_r_addr <= '0;
            else if (bus.i_r_addr_wen)
                r_r_addr <= r_r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.o_pc           = r_pc;
    assign bus.o_nops_cntr_we = w_we;
    assign bus.o_all_done     = r_all_done;
    assign bus.o_x_addr       = r_x_addr;
    assign bus.o_r_addr       = r_r_addr;
    assign bus.o_p_done       = w_p_done;
    assign bus.o_p_last_bound =
        (({1'b0, r_p_cnt} + 9'd1) == {1'b0, w_p});
    assign bus.o_beta_done    = (r_row == {1'b0, w_beta});
    assign bus.o_beta_last_bound =
        (({1'b0, r_row} + 10'd1) == {2'b00, w_beta});
    assign bus.o_alp_plus_beta_done = (r_row == w_apb);
    assign bus.o_alp_plus_beta_last_bound =
        (({1'b0, r_row} + 10'd1) == {1'b0, w_apb});
endmodule

// File: tb/tb_rosetta_loop_sequencer.sv
// Scoreboard bench for rosetta_loop_sequencer against an integer reference model.
// Directed loop/NOP/pointer/halt/reset phases followed by random traffic.
module tb_rosetta_loop_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rosetta_loop_sequencer_if #(.ADDR_W(10), .IM_AW(8)) bus ();
    rosetta_loop_sequencer #(.ADDR_W(10), .IM_AW(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        int pc, x, r;
        bit we, pl, pd, bl, bd, al, ad, nd, all;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] cur_inst;

    int m_pc, m_p, m_row, m_nop, m_x, m_r;
    bit m_first, m_pend, m_run, m_all;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(int p, int n, int a, int b);
        logic [31:0] w;
        w = {b[7:0], a[6:0], 1'b0, n[5:0], p[7:0], 2'b01};
        return w;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_p = 0; m_row = 0; m_nop = 0; m_x = 0; m_r = 0;
        m_first = 1; m_pend = 0; m_run = 0; m_all = 0;
    endtask

    // Expected outputs for the current cycle, then advance the model one edge
    task automatic step();
        exp_t e;
        logic [31:0] w;
        int P, N, A, B, S;
        bit we;
        w = bus.i_inst;
        P = int'(w[9:2]);
        N = int'(w[15:10]);
        A = int'(w[23:17]);
        B = int'(w[31:24]);
        S = A + B;
        we = m_first || m_pend;
        e.pc = m_pc; e.x = m_x; e.r = m_r; e.we = we;
        e.pd = (m_p == P);
        e.pl = (m_p + 1 == P);
        e.bd = (m_row == B);
        e.bl = (m_row + 1 == B);
        e.ad = (m_row == S);
        e.al = (m_row + 1 == S);
`ifdef ROSETTA_SEQ_NOPS_EN
        e.nd = m_run && (m_nop == 0);
`else
        e.nd = 1'b1;
`endif
        e.all = m_all;
        q.push_back(e);
        if (we) begin
            m_p = 0; m_row = 0; m_run = 0; m_nop = N;
            if (w == 32'hFFFF_FFFF) m_all = 1;
        end else begin
            if (bus.i_pam_x_ren) begin
                if (m_p == P) begin
                    m_p = 0;
                    if (m_row < S) m_row++;
                end else begin
                    m_p = (m_p + 1) % 256;
                end
            end
            if (m_run && m_nop > 0) m_nop--;
            if (bus.i_inst_done) m_run = 1;
        end
        m_pc = (m_pc + (bus.i_im_ren ? 1 : 0)) % 256;
        m_pend = bus.i_im_ren;
        m_first = 0;
        if (bus.i_x_addr_rst) m_x = 0;
        else if (bus.i_x_addr_wen) m_x = (m_x + 1) % 1024;
        if (bus.i_r_addr_rst) m_r = 0;
        else if (bus.i_r_addr_wen) m_r = (m_r + 1) % 1024;
    endtask

    task automatic drive(input bit ren, pam, xw, rw, xr, rr, dn);
        bus.i_inst = cur_inst;
        bus.i_im_ren = ren;
        bus.i_pam_x_ren = pam;
        bus.i_x_addr_wen = xw;
        bus.i_r_addr_wen = rw;
        bus.i_x_addr_rst = xr;
        bus.i_r_addr_rst = rr;
        bus.i_inst_done = dn;
    endtask

    task automatic cyc(input bit ren, pam, xw, rw, xr, rr, dn);
        @(posedge clk);
        #1;
        drive(ren, pam, xw, rw, xr, rr, dn);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fetch(input logic [31:0] w);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cur_inst = w;
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Caller raises the edge-free window; reset is checked before any clock
    task automatic reset_body();
        rst = 1'b1;
        #1;
        chk("rst_pc", 32'(bus.o_pc), 0);
        chk("rst_we", 32'(bus.o_nops_cntr_we), 0);
        chk("rst_all_done", 32'(bus.o_all_done), 0);
        chk("rst_x_addr", 32'(bus.o_x_addr), 0);
        chk("rst_r_addr", 32'(bus.o_r_addr), 0);
`ifdef ROSETTA_SEQ_NOPS_EN
        chk("rst_nops_done", 32'(bus.o_nops_done), 0);
`else
        chk("rst_nops_done", 32'(bus.o_nops_done), 1);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", 32'(bus.o_pc), e.pc);
                chk("nops_cntr_we", 32'(bus.o_nops_cntr_we), 32'(e.we));
                chk("p_last_bound", 32'(bus.o_p_last_bound), 32'(e.pl));
                chk("p_done", 32'(bus.o_p_done), 32'(e.pd));
                chk("beta_last_bound", 32'(bus.o_beta_last_bound), 32'(e.bl));
                chk("beta_done", 32'(bus.o_beta_done), 32'(e.bd));
                chk("apb_last_bound",
                    32'(bus.o_alp_plus_beta_last_bound), 32'(e.al));
                chk("apb_done", 32'(bus.o_alp_plus_beta_done), 32'(e.ad));
                chk("nops_done", 32'(bus.o_nops_done), 32'(e.nd));
                chk("all_done", 32'(bus.o_all_done), 32'(e.all));
                chk("x_addr", 32'(bus.o_x_addr), e.x);
                chk("r_addr", 32'(bus.o_r_addr), e.r);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] w;
        cur_inst = mk(3, 4, 1, 2);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        reset_body();

        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(8);

        fetch(mk(0, 0, 0, 3));
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0, 0);
        idle(1);
        for (int i = 0; i < 1026; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                w = mk($urandom_range(0, 4), $urandom_range(0, 5),
                       $urandom_range(0, 3), $urandom_range(0, 3));
                w[0] = 1'($urandom);
                w[1] = 1'($urandom);
                w[16] = 1'($urandom);
                fetch(w);
            end else begin
                cyc(0, 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 9) == 0);
            end
        end

        fetch(32'hFFFF_FFFF);
        idle(4);
        fetch(mk(2, 1, 1, 1));
        idle(3);

        fetch(mk(3, 2, 1, 2));
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        #2;
        reset_body();
        for (int i = 0; i < 4; i++) fetch(mk(1, 1, 1, 1));
        idle(3);

        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rosetta_loop_sequencer.md
# rosetta_loop_sequencer

Sequential loop-bound generator for the ROSETTA instruction controller.
- Tracks instruction fetch, the P-element and row loop counters, the trailing-NOP counter and the X/R address pointers.
- Produces the done and last-bound flags that the combinational controller decodes.
- Consumes that controller's enables and resets.
- Sits between instruction memory and the controller; its outputs feed the controller directly.

## Interface
- `ADDR_W`, 10: width of the `x_addr` and `r_addr` pointers.
- `IM_AW`, 8: width of the instruction-memory address `pc`.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `inst` in, 32: current instruction word; valid in the cycle after a fetch.
- `im_ren` in, 1: fetch request from the controller.
- `pam_x_ren` in, 1: P-loop step enable.
- `x_addr_wen`, `r_addr_wen` in, 1 each: pointer increment enables.
- `x_addr_rst`, `r_addr_rst` in, 1 each: pointer clear requests.
- `inst_done` in, 1: single-instruction done, from the controller.
- `pc` out, IM_AW: instruction-memory read address.
- `nops_cntr_we` out, 1: marks the first cycle of each instruction.
- `p_last_bound`, `p_done` out, 1 each: P-loop flags.
- `beta_last_bound`, `beta_done` out, 1 each: beta-row flags.
- `alp_plus_beta_last_bound`, `alp_plus_beta_done` out, 1 each: total-row flags.
- `nops_done` out, 1: trailing NOPs finished.
- `all_done` out, 1: program halted.
- `x_addr`, `r_addr` out, ADDR_W each: PAM pointers.

## Operation
- **Instruction fields.**
  - `P = inst[9:2]`
  - `NOPS = inst[15:10]`
  - `ALPHA = inst[23:17]`
  - `BETA = inst[31:24]`
  - `inst[0]`, `inst[1]` and `inst[16]` are decoded by the controller only.
  - `inst == 32'hFFFF_FFFF` is HALT.
- **Fetch.**
  - `pc` increments by 1 on each cycle with `im_ren` high, wrapping at 2^IM_AW.
  - `nops_cntr_we` is `im_ren` registered one cycle.
  - `nops_cntr_we` is also forced high in the first cycle after reset deasserts, so the word at `pc = 0` is processed.
- **On `nops_cntr_we`** (new instruction):
  - `p_cnt`, `row` and the NOP run flag clear.
  - `nop_cnt` loads `NOPS`.
  - If `inst` is HALT, `all_done` sets and stays set until reset.
- **P counter** (8 b).
  - Increments when `pam_x_ren` is high.
  - When `p_done & pam_x_ren`, it wraps to 0 instead and `row` increments.
  - `p_done = (p_cnt == P)`.
  - `p_last_bound = (p_cnt + 1 == P)`.
  - With `P = 0`, `p_done` is immediate and `p_last_bound` never asserts.
- **Row counter** (9 b).
  - `beta_done = (row == BETA)`; `beta_last_bound = (row + 1 == BETA)`.
  - `alp_plus_beta_done = (row == ALPHA + BETA)`, where the sum is computed 9 b wide with no overflow.
  - `alp_plus_beta_last_bound = (row + 1 == ALPHA + BETA)`.
  - `row` saturates at `ALPHA + BETA`.
- **NOP counter** (6 b).
  - `inst_done` sets the run flag.
  - While the run flag is set and `nop_cnt != 0`, `nop_cnt` decrements each cycle.
  - `nops_done = run & (nop_cnt == 0)`.
- **Pointers.**
  - Clear has priority over increment, i.e. `*_rst` wins over `*_wen` in the same cycle.
  - Increment wraps at 2^ADDR_W.
  - Pointers are not cleared by `nops_cntr_we`.
- **Interaction between `nops_cntr_we` and other inputs.** When `nops_cntr_we` coincides with `pam_x_ren` or `inst_done`, the reload wins for the P, row and NOP state.

## Timing
- **Reset values:**
  - `pc = 0`, `x_addr = 0`, `r_addr = 0`.
  - `nops_cntr_we = 0` during reset; it is 1 in the first cycle after reset deasserts.
  - `all_done = 0`, `nops_done = 0`, internal counters 0.
- **Flag generation.** All flags are combinational from registered counters and the current `inst`; they are valid in the same cycle as the counter value.
- **Fetch to reload.** `im_ren` in cycle t gives `nops_cntr_we` in t+1, and counters reload at the end of t+1.
- **NOP latency.** `inst_done` in cycle t with `NOPS = N` gives `nops_done` high in cycle t+1+N.
- **Halt.**
  - `all_done` rises in the cycle after the HALT `nops_cntr_we`.
  - Further `im_ren` still increments `pc`; the controller suppresses it.
- **Reset mid-operation.** Asynchronous reset returns all state to the reset values immediately, and fetch restarts at `pc = 0`.

## Configuration
- Macro: `ROSETTA_SEQ_NOPS_EN`.
- **Defined:** the NOP counter is built as described in Operation.
- **Undefined:**
  - The NOP counter and run flag are removed.
  - `nops_done` is tied to 1.
  - The `NOPS` field is ignored.
  - All other behaviour is unchanged.

## Test plan
- **Reset and first fetch.** Reset, then release → `pc = 0`; `nops_cntr_we = 1` for exactly one cycle; all flags consistent with the `inst` at address 0.
- **P-loop wrap.** `P = 3`, `BETA = 2`, `ALPHA = 1`, `pam_x_ren` held high →
  - `p_last_bound` at `p_cnt = 2`;
  - `p_done` at 3, then wrap to 0 with `row` = 1;
  - `beta_done` at `row = 2`;
  - `alp_plus_beta_done` at `row = 3`, then `row` holds.
- **Zero P.** `P = 0` → `p_done` high whenever `p_cnt = 0`; `p_last_bound` never asserts; `row` increments on every `pam_x_ren` cycle.
- **NOP countdown.** `NOPS = 4`, `inst_done` pulse at t → `nops_done` low through t+4, high at t+5; it clears on the next `nops_cntr_we`. With the macro undefined, `nops_done` is constantly 1.
- **Pointer priority.** `x_addr_wen = 1` for 5 cycles → `x_addr = 5`. Then `x_addr_rst` and `x_addr_wen` together → 0. Test `r_addr` wrap from 1023 → 0 with ADDR_W = 10.
- **Halt and reset.** HALT word fetched → `all_done = 1` one cycle after its `nops_cntr_we`, sticky. Asserting `rst` mid-loop → all outputs return to reset values asynchronously.
